reg_bank_arbiter: RTL and testbench

- Shares one config register bank between two requesters: requester 0 is the AXI register port (reg_wr_*/reg_rd_*), requester 1 is the internal controller.
- The bank holds CFG_REGS config registers followed by the SDP RAM words.
- Arbitration is round-robin between the two requesters.
- Each byte address is decoded to a word offset. Out-of-range accesses get an error response.
- Exactly one bank operation is in flight at a time.

---
 rtl/reg_bank_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one config/SDP-RAM register bank between the AXI
// register port (requester 0) and the internal controller (requester 1).

module rba_decode #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASEADDR   = 32'hA000_0000,
  parameter int                    NUM_WORDS  = 64,
  parameter int                    OFS_W      = 6
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [OFS_W-1:0]      ofs_o,
  output logic                  valid_o
);
  logic [ADDR_WIDTH-1:0] word;

  // Full-width word index so wrapped (below-base) addresses fail the range test.
  assign word    = (addr_i - BASEADDR) >> 2;
  assign ofs_o   = word[OFS_W-1:0];
  assign valid_o = (addr_i >= BASEADDR) && (addr_i[1:0] == 2'b00) &&
                   (word < ADDR_WIDTH'(NUM_WORDS));
endmodule

module reg_bank_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASEADDR   = 32'hA000_0000,
  parameter int                    CFG_REGS   = 16,
  parameter int                    RAM_DEPTH  = 48,
  parameter int                    OFS_W      = $clog2(CFG_REGS + RAM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [1:0]                 wr_en,
  input  logic [1:0][ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0][DATA_WIDTH-1:0] wr_data,
  output logic [1:0]                 wr_ack,
  input  logic [1:0]                 rd_en,
  input  logic [1:0][ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0][DATA_WIDTH-1:0] rd_data,
  output logic [1:0]                 rd_ack,
  output logic [1:0]                 err,
  output logic                       bank_we,
  output logic                       bank_re,
  output logic [OFS_W-1:0]           bank_ofs,
  output logic                       bank_is_cfg,
  output logic [DATA_WIDTH-1:0]      bank_wdata,
  input  logic [DATA_WIDTH-1:0]      bank_rdata
);
  localparam int NUM_REQ   = 2;
  localparam int NUM_WORDS = CFG_REGS + RAM_DEPTH;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_ACK} state_e;

  state_e state_q, state_d;
  logic   rr_q, rr_d;
  logic   req_q, req_d;

  logic [NUM_REQ-1:0][OFS_W-1:0] wr_ofs, rd_ofs;
  logic [NUM_REQ-1:0]            wr_valid, rd_valid;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    rba_decode #(
      .ADDR_WIDTH(ADDR_WIDTH), .BASEADDR(BASEADDR),
      .NUM_WORDS (NUM_WORDS),  .OFS_W   (OFS_W)
    ) u_wr_dec (
      .addr_i(wr_addr[r]), .ofs_o(wr_ofs[r]), .valid_o(wr_valid[r])
    );
    rba_decode #(
      .ADDR_WIDTH(ADDR_WIDTH), .BASEADDR(BASEADDR),
      .NUM_WORDS (NUM_WORDS),  .OFS_W   (OFS_W)
    ) u_rd_dec (
      .addr_i(rd_addr[r]), .ofs_o(rd_ofs[r]), .valid_o(rd_valid[r])
    );
  end

  logic [NUM_REQ-1:0] pend;
  logic               any_pend, gnt, gnt_wr, gnt_valid;
  logic [OFS_W-1:0]   gnt_ofs;

  // rr only breaks ties; a lone pending requester is always taken.
  always_comb begin
    pend      = wr_en | rd_en;
    any_pend  = |pend;
    gnt       = (&pend) ? rr_q : pend[1];
    gnt_wr    = wr_en[gnt];
    gnt_valid = gnt_wr ? wr_valid[gnt] : rd_valid[gnt];
    gnt_ofs   = gnt_wr ? wr_ofs[gnt] : rd_ofs[gnt];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          rr_d  = ~gnt;
          req_d = gnt;
          if (gnt_wr)         state_d = WR;
          else if (gnt_valid) state_d = RD;
          else                state_d = RD_ACK;
        end
      end
      WR:      state_d = IDLE;
      RD:      state_d = RD_ACK;
      RD_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [NUM_REQ-1:0]                 wr_ack_q, wr_ack_d;
  logic [NUM_REQ-1:0]                 rd_ack_q, rd_ack_d;
  logic [NUM_REQ-1:0]                 err_q, err_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                               bank_we_q, bank_we_d;
  logic                               bank_re_q, bank_re_d;
  logic [OFS_W-1:0]                   bank_ofs_q, bank_ofs_d;
  logic                               bank_is_cfg_q, bank_is_cfg_d;
  logic [DATA_WIDTH-1:0]              bank_wdata_q, bank_wdata_d;

  // Outputs are registered, so each value is computed for the state being entered.
  always_comb begin
    wr_ack_d      = '0;
    rd_ack_d      = '0;
    err_d         = '0;
    rd_data_d     = rd_data_q;
    bank_we_d     = 1'b0;
    bank_re_d     = 1'b0;
    bank_ofs_d    = '0;
    bank_is_cfg_d = 1'b0;
    bank_wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          if (gnt_wr) begin
            wr_ack_d[gnt] = 1'b1;
            if (gnt_valid) begin
              bank_we_d     = 1'b1;
              bank_ofs_d    = gnt_ofs;
              bank_is_cfg_d = gnt_ofs < OFS_W'(CFG_REGS);
              bank_wdata_d  = wr_data[gnt];
            end else begin
              err_d[gnt] = 1'b1;
            end
          end else if (gnt_valid) begin
            bank_re_d     = 1'b1;
            bank_ofs_d    = gnt_ofs;
            bank_is_cfg_d = gnt_ofs < OFS_W'(CFG_REGS);
          end else begin
            rd_ack_d[gnt]  = 1'b1;
            err_d[gnt]     = 1'b1;
            rd_data_d[gnt] = ERR_DATA;
          end
        end
      end
      RD: begin
        rd_ack_d[req_q]  = 1'b1;
        rd_data_d[req_q] = bank_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ack_q      <= '0;
      rd_ack_q      <= '0;
      err_q         <= '0;
      rd_data_q     <= '0;
      bank_we_q     <= 1'b0;
      bank_re_q     <= 1'b0;
      bank_ofs_q    <= '0;
      bank_is_cfg_q <= 1'b0;
      bank_wdata_q  <= '0;
    end else begin
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
      err_q         <= err_d;
      rd_data_q     <= rd_data_d;
      bank_we_q     <= bank_we_d;
      bank_re_q     <= bank_re_d;
      bank_ofs_q    <= bank_ofs_d;
      bank_is_cfg_q <= bank_is_cfg_d;
      bank_wdata_q  <= bank_wdata_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign rd_ack      = rd_ack_q;
  assign err         = err_q;
  assign rd_data     = rd_data_q;
  assign bank_we     = bank_we_q;
  assign bank_re     = bank_re_q;
  assign bank_ofs    = bank_ofs_q;
  assign bank_is_cfg = bank_is_cfg_q;
  assign bank_wdata  = bank_wdata_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: transaction-level model predicting every output
// cycle, directed scenarios with literal expectations, then random traffic.

module tb_reg_bank_arbiter;
  localparam int AW = 32, DW = 32, CFG = 16, RAMD = 48, TOT = CFG + RAMD, OW = 6;
  localparam logic [31:0] BASE = 32'hA000_0000;

  logic                clk = 1'b0, rstn;
  logic [1:0]          wr_en, rd_en, wr_ack, rd_ack, err;
  logic [1:0][AW-1:0]  wr_addr, rd_addr;
  logic [1:0][DW-1:0]  wr_data, rd_data;
  logic                bank_we, bank_re, bank_is_cfg;
  logic [OW-1:0]       bank_ofs;
  logic [DW-1:0]       bank_wdata, bank_rdata;

  reg_bank_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASEADDR(BASE),
    .CFG_REGS(CFG), .RAM_DEPTH(RAMD)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .err(err), .bank_we(bank_we), .bank_re(bank_re), .bank_ofs(bank_ofs),
    .bank_is_cfg(bank_is_cfg), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  // Bank: combinational read, so the word is sampled one clock after bank_re launches.
  logic [DW-1:0] mem [TOT];
  logic          seed_en;
  logic [OW-1:0] seed_ofs;
  logic [DW-1:0] seed_val;
  assign bank_rdata = mem[bank_ofs];
  always @(posedge clk) begin
    if (bank_we)      mem[bank_ofs] <= bank_wdata;
    else if (seed_en) mem[seed_ofs] <= seed_val;
  end

  typedef struct {
    logic               we, re, cfg;
    logic [OW-1:0]      ofs;
    logic [DW-1:0]      wdata;
    logic [1:0]         wack, rack, err;
    logic [1:0][DW-1:0] rdata;
  } out_t;

  out_t               sched[$];
  out_t               cur;
  int                 mrr;
  logic [DW-1:0]      mmem [TOT];
  logic [1:0][DW-1:0] mrd;
  int                 checks = 0, errors = 0;

  function automatic out_t idle_out();
    out_t o;
    o.we = 0; o.re = 0; o.cfg = 0; o.ofs = '0; o.wdata = '0;
    o.wack = '0; o.rack = '0; o.err = '0; o.rdata = mrd;
    return o;
  endfunction

  function automatic bit in_range(logic [31:0] a);
    longint d = longint'(a) - longint'(BASE);
    return d >= 0 && d % 4 == 0 && d / 4 < TOT;
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("wr_ack", 64'(wr_ack), 64'(cur.wack));
    chk("rd_ack", 64'(rd_ack), 64'(cur.rack));
    chk("err", 64'(err), 64'(cur.err));
    chk("bank_we", 64'(bank_we), 64'(cur.we));
    chk("bank_re", 64'(bank_re), 64'(cur.re));
    chk("rd_data", 64'(rd_data), 64'(cur.rdata));
    if (cur.we || cur.re) begin
      chk("bank_ofs", 64'(bank_ofs), 64'(cur.ofs));
      chk("bank_is_cfg", 64'(bank_is_cfg), 64'(cur.cfg));
    end
    if (cur.we) chk("bank_wdata", 64'(bank_wdata), 64'(cur.wdata));
  endtask

  // One op at a time; after it the arbiter spends one idle cycle before the next grant.
  task automatic model_step();
    out_t o;
    int   g, w;
    bit   p0, p1;
    if (!rstn) begin
      sched.delete(); mrr = 0; mrd = '0; cur = idle_out();
      return;
    end
    if (sched.size() == 0) begin
      p0 = wr_en[0] | rd_en[0];
      p1 = wr_en[1] | rd_en[1];
      if (p0 || p1) begin
        g   = (p0 && p1) ? mrr : (p1 ? 1 : 0);
        mrr = 1 - g;
        if (wr_en[g]) begin
          o = idle_out(); o.wack[g] = 1'b1;
          if (in_range(wr_addr[g])) begin
            w = word_of(wr_addr[g]);
            o.we = 1; o.ofs = OW'(w); o.cfg = (w < CFG); o.wdata = wr_data[g];
            mmem[w] = wr_data[g];
          end else o.err[g] = 1'b1;
          sched.push_back(o);
        end else if (in_range(rd_addr[g])) begin
          w = word_of(rd_addr[g]);
          o = idle_out(); o.re = 1; o.ofs = OW'(w); o.cfg = (w < CFG);
          sched.push_back(o);
          mrd[g] = mmem[w];
          o = idle_out(); o.rack[g] = 1'b1;
          sched.push_back(o);
        end else begin
          mrd[g] = 32'hDEAD_BEEF;
          o = idle_out(); o.rack[g] = 1'b1; o.err[g] = 1'b1;
          sched.push_back(o);
        end
        sched.push_back(idle_out());
      end
    end
    cur = (sched.size() != 0) ? sched.pop_front() : idle_out();
  endtask

  task automatic pre();
    @(negedge clk);
    compare();
    for (int r = 0; r < 2; r++) begin
      if (cur.wack[r]) wr_en[r] = 1'b0;
      if (cur.rack[r]) rd_en[r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + 32'(TOT * 4) + 32'(4 * $urandom_range(0, 15));
      1:       return BASE - 32'(4 * $urandom_range(1, 4));
      2:       return BASE + 32'(4 * $urandom_range(0, TOT - 1)) + 32'($urandom_range(1, 3));
      default: return BASE + 32'(4 * $urandom_range(0, TOT - 1));
    endcase
  endfunction

  task automatic gen();
    for (int r = 0; r < 2; r++) begin
      if (!wr_en[r] && !rd_en[r] && $urandom_range(0, 2) == 0) begin
        int k = $urandom_range(0, 2);
        if (k != 1) begin wr_en[r] = 1'b1; wr_addr[r] = rand_addr(); wr_data[r] = $urandom; end
        if (k != 0) begin rd_en[r] = 1'b1; rd_addr[r] = rand_addr(); end
      end
    end
  endtask

  task automatic tick(bit rnd);
    pre();
    if (rnd) gen();
    model_step();
  endtask

  logic [31:0] bad_addr [3];

  initial begin
    wr_en = '0; rd_en = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    seed_en = 0; seed_ofs = '0; seed_val = '0;
    mrr = 0; mrd = '0; cur = idle_out();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    for (int i = 0; i < TOT; i++) begin
      pre(); seed_en = 1; seed_ofs = OW'(i); seed_val = $urandom; mmem[i] = seed_val; model_step();
    end
    pre(); seed_en = 0;
    chk("rst_outputs", {wr_ack, rd_ack, err, bank_we, bank_re, bank_is_cfg}, '0);
    chk("rst_rd_data", 64'(rd_data), '0);
    model_step();
    pre(); rstn = 1'b1; model_step();
    repeat (2) tick(0);

    // Single cfg write from requester 0
    pre(); wr_en[0] = 1; wr_addr[0] = 32'hA000_0008; wr_data[0] = 32'h1234_5678; model_step();
    pre();
    chk("t1_we", 64'(bank_we), 1); chk("t1_ofs", 64'(bank_ofs), 2);
    chk("t1_cfg", 64'(bank_is_cfg), 1); chk("t1_wack", 64'(wr_ack), 1);
    chk("t1_wdata", 64'(bank_wdata), 64'h1234_5678);
    model_step();
    repeat (2) tick(0);

    // RAM read from requester 1
    pre(); seed_en = 1; seed_ofs = 16; seed_val = 32'hCAFE_0001; mmem[16] = 32'hCAFE_0001; model_step();
    pre(); seed_en = 0; rd_en[1] = 1; rd_addr[1] = 32'hA000_0040; model_step();
    pre();
    chk("t2_re", 64'(bank_re), 1); chk("t2_ofs", 64'(bank_ofs), 16);
    chk("t2_cfg", 64'(bank_is_cfg), 0); chk("t2_rack_early", 64'(rd_ack), 0);
    model_step();
    pre(); chk("t2_rack", 64'(rd_ack), 2); chk("t2_rdata", 64'(rd_data[1]), 64'hCAFE_0001); model_step();
    repeat (2) tick(0);

    // Both writing together, twice: order 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      pre();
      wr_en = 2'b11;
      wr_addr[0] = BASE + 32'(4 * (20 + k)); wr_data[0] = 32'h0A00_0000 + 32'(k);
      wr_addr[1] = BASE + 32'(4 * (30 + k)); wr_data[1] = 32'h0B00_0000 + 32'(k);
      model_step();
      pre(); chk("t3_first", 64'(wr_ack), 1); model_step();
      pre(); chk("t3_gap", 64'(wr_ack), 0); model_step();
      pre(); chk("t3_second", 64'(wr_ack), 2); model_step();
    end
    repeat (2) tick(0);

    // Write and read together from requester 0: write first, read sees new data
    pre();
    wr_en[0] = 1; rd_en[0] = 1; wr_addr[0] = 32'hA000_0010; rd_addr[0] = 32'hA000_0010;
    wr_data[0] = 32'h55AA_1234;
    model_step();
    pre(); chk("t4_wack", 64'(wr_ack), 1); chk("t4_rack_early", 64'(rd_ack), 0); model_step();
    pre(); model_step();
    pre(); chk("t4_re", 64'(bank_re), 1); model_step();
    pre(); chk("t4_rack", 64'(rd_ack), 1); chk("t4_rdata", 64'(rd_data[0]), 64'h55AA_1234); model_step();
    repeat (2) tick(0);

    // Out-of-range reads
    bad_addr[0] = 32'hA000_0100; bad_addr[1] = 32'h9FFF_FFFC; bad_addr[2] = 32'hA000_0002;
    for (int i = 0; i < 3; i++) begin
      pre(); rd_en[0] = 1; rd_addr[0] = bad_addr[i]; model_step();
      pre();
      chk("t5_re", 64'(bank_re), 0); chk("t5_rack", 64'(rd_ack), 1);
      chk("t5_err", 64'(err), 1); chk("t5_rdata", 64'(rd_data[0]), 64'hDEAD_BEEF);
      model_step();
      tick(0);
    end

    // Reset during RD from requester 0 (leaves rr pointing at 1 before reset)
    pre(); rd_en[0] = 1; rd_addr[0] = 32'hA000_0044; model_step();
    pre(); chk("t6_re", 64'(bank_re), 1); rstn = 0; wr_en = '0; rd_en = '0; model_step();
    repeat (2) begin
      pre();
      chk("t6_no_ack", {wr_ack, rd_ack, err, bank_we, bank_re}, '0);
      chk("t6_rd_data", 64'(rd_data), '0);
      model_step();
    end
    pre(); rstn = 1; model_step();
    tick(0);
    pre();
    wr_en = 2'b11; wr_addr[0] = 32'hA000_0020; wr_addr[1] = 32'hA000_0024;
    wr_data[0] = 32'h1111_0000; wr_data[1] = 32'h2222_0000;
    model_step();
    pre(); chk("t6_rr_reset", 64'(wr_ack), 1); model_step();
    repeat (4) tick(0);

    repeat (4000) tick(1);
    repeat (10) tick(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
